// File: rtl/generador_desplazamiento.sv
// Wheel-pulse debouncer and distance accumulator (Q24.8 m) publishing the distance as a half-float.
// Optional macro REVERSA_EN adds a `sentido` input that makes pulses subtract instead of add.
module generador_desplazamiento #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned STEP_Q8         = 52
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pulso_rueda,
   input  logic        borrar,
`ifdef REVERSA_EN
   input  logic        sentido,
`endif
   output logic [15:0] desplazamientof,
   output logic        actualizado,
   output logic [31:0] contadorPulsos,
   output logic        saturado
);

   localparam logic [15:0] DEB_LIMIT = 16'(DEBOUNCE_CYCLES);
   localparam logic [31:0] STEP      = 32'(STEP_Q8);
   localparam logic [15:0] HALF_MAX  = 16'h7BFF;

   logic [1:0]  sync_pulso;
   logic        nivel;
   logic        nivel_d;
   logic [15:0] cnt;
   logic [31:0] acc;
   logic        evento;
   logic        reversa;

   logic        pulso_c;
   logic [15:0] cnt_inc_c;
   logic [32:0] suma_c;
   logic [31:0] acc_next_c;
   logic [4:0]  lead_c;
   logic [9:0]  mant_c;
   logic [15:0] half_c;

`ifdef REVERSA_EN
   logic [1:0] sync_sentido;

   // Direction input gets its own synchronizer
   always_ff @(posedge clock) begin
      if (reset) sync_sentido <= 2'b00;
      else       sync_sentido <= {sync_sentido[0], sentido};
   end

   assign reversa = sync_sentido[1];
`else
   assign reversa = 1'b0;
`endif

   // Synchronizer and debouncer
   assign cnt_inc_c = cnt + 16'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_pulso <= 2'b00;
         nivel      <= 1'b0;
         nivel_d    <= 1'b0;
         cnt        <= 16'd0;
      end else begin
         sync_pulso <= {sync_pulso[0], pulso_rueda};
         nivel_d    <= nivel;
         if (sync_pulso[1] == nivel) begin
            cnt <= 16'd0;
         end else if (cnt_inc_c == DEB_LIMIT) begin
            nivel <= ~nivel;
            cnt   <= 16'd0;
         end else begin
            cnt <= cnt_inc_c;
         end
      end
   end

   assign pulso_c = nivel & ~nivel_d;

   // Saturating step in either direction
   always_comb begin
      suma_c     = {1'b0, acc} + {1'b0, STEP};
      acc_next_c = suma_c[32] ? 32'hFFFF_FFFF : suma_c[31:0];
      if (reversa) begin
         acc_next_c = (acc < STEP) ? 32'd0 : (acc - STEP);
      end
   end

   // Accumulator and pulse counter; a clear drops a coincident pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         acc            <= 32'd0;
         contadorPulsos <= 32'd0;
         evento         <= 1'b0;
      end else begin
         evento <= pulso_c | borrar;
         if (borrar) begin
            acc            <= 32'd0;
            contadorPulsos <= 32'd0;
         end else if (pulso_c) begin
            acc            <= acc_next_c;
            contadorPulsos <= contadorPulsos + 32'd1;
         end
      end
   end

   // Q24.8 to half-float: exponent bias 15 minus the 8 fractional bits gives p+7
   always_comb begin
      lead_c = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (acc[i]) lead_c = 5'(i);
      end
      mant_c = 10'((acc << (5'd31 - lead_c)) >> 5'd21);
      if (acc == 32'd0) begin
         half_c = 16'h0000;
      end else if (lead_c > 5'd23) begin
         half_c = HALF_MAX;
      end else begin
         half_c = {1'b0, 5'(lead_c + 5'd7), mant_c};
      end
   end

   // Output register, rewritten once per event
   always_ff @(posedge clock) begin
      if (reset) begin
         desplazamientof <= 16'h0000;
         saturado        <= 1'b0;
         actualizado     <= 1'b0;
      end else begin
         actualizado <= evento;
         if (evento) begin
            desplazamientof <= half_c;
            saturado        <= |acc[31:24];
         end
      end
   end

endmodule
